// File: rtl/reg_dump_seq.sv
// rtl/reg_dump_seq.sv - debug register readout sequencer streaming tagged bytes
//
// Walks the debug readout mux through groups A (00/0..15), B (01/0..4) and
// C (11/14, 11/15). Each word is captured once and sent as three bytes:
// {sel,2'b00,reg_sel}, data[15:8], data[7:0].
//
// Ports:
//   clk, reset        clock (rising edge), asynchronous active-high reset
//   start, abort      begin dump (honoured in IDLE), abort (honoured outside IDLE)
//   sel, reg_sel      readout mux group / register select
//   reg_data          word returned by the readout mux
//   tx_data, tx_valid, tx_ready   byte stream
//   busy, done        dump in progress, one-cycle completion pulse
module reg_dump_seq #(
    parameter int unsigned SETTLE           = 1,
    parameter bit          INCLUDE_INTERNAL = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    output logic [1:0]  sel,
    output logic [3:0]  reg_sel,
    input  logic [15:0] reg_data,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        done
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_TAG   = 3'd2;
    localparam logic [2:0] ST_HI    = 3'd3;
    localparam logic [2:0] ST_LO    = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    localparam logic [2:0] SETTLE_CNT = 3'(SETTLE);

    logic [2:0]  state;
    logic [2:0]  cnt;
    logic [15:0] cap;
    logic        fire;
    logic        last_addr;
    logic [1:0]  next_sel;
    logic [3:0]  next_reg_sel;

    assign fire = tx_valid && tx_ready;

    // Address successor; only the two group boundaries jump, unmapped codes
    // are skipped entirely.
    always_comb begin
        next_sel     = sel;
        next_reg_sel = reg_sel + 4'd1;
        if (sel == 2'b00 && reg_sel == 4'd15) begin
            next_sel     = 2'b01;
            next_reg_sel = 4'd0;
        end else if (sel == 2'b01 && reg_sel == 4'd4) begin
            next_sel     = 2'b11;
            next_reg_sel = 4'd14;
        end
    end

    always_comb begin
        if (INCLUDE_INTERNAL) begin
            last_addr = (sel == 2'b11) && (reg_sel == 4'd15);
        end else begin
            last_addr = (sel == 2'b00) && (reg_sel == 4'd15);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            cnt      <= 3'd0;
            cap      <= 16'h0000;
            sel      <= 2'b00;
            reg_sel  <= 4'd0;
            tx_data  <= 8'h00;
            tx_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else if (abort && state != ST_IDLE) begin
            // Abort outranks any transfer happening on this same edge.
            state    <= ST_IDLE;
            cnt      <= 3'd0;
            sel      <= 2'b00;
            reg_sel  <= 4'd0;
            tx_data  <= 8'h00;
            tx_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state   <= ST_SETUP;
                        cnt     <= 3'd0;
                        sel     <= 2'b00;
                        reg_sel <= 4'd0;
                        busy    <= 1'b1;
                    end
                end
                ST_SETUP: begin
                    if (cnt == SETTLE_CNT) begin
                        // Capture once so later reg_data movement cannot
                        // corrupt the bytes still waiting for the link.
                        cap      <= reg_data;
                        tx_data  <= {sel, 2'b00, reg_sel};
                        tx_valid <= 1'b1;
                        state    <= ST_TAG;
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                ST_TAG: begin
                    if (fire) begin
                        tx_data <= cap[15:8];
                        state   <= ST_HI;
                    end
                end
                ST_HI: begin
                    if (fire) begin
                        tx_data <= cap[7:0];
                        state   <= ST_LO;
                    end
                end
                ST_LO: begin
                    if (fire) begin
                        tx_valid <= 1'b0;
                        tx_data  <= 8'h00;
                        cnt      <= 3'd0;
                        if (last_addr) begin
                            state   <= ST_DONE;
                            sel     <= 2'b00;
                            reg_sel <= 4'd0;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            state   <= ST_SETUP;
                            sel     <= next_sel;
                            reg_sel <= next_reg_sel;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state    <= ST_IDLE;
                    tx_valid <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_dump_seq.sv
// tb/tb_reg_dump_seq.sv - directed bench for reg_dump_seq
module tb_reg_dump_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        abort = 1'b0;
    logic        tx_ready = 1'b1;
    logic        go = 1'b0;
    logic        use0 = 1'b0;
    logic        override = 1'b0;

    logic        start, start0;
    logic [1:0]  sel, sel0;
    logic [3:0]  reg_sel, reg_sel0;
    logic [15:0] reg_data, reg_data0;
    logic [7:0]  tx_data, tx_data0;
    logic        tx_valid, tx_valid0, busy, busy0, done, done0;

    logic [7:0]  m_data;
    logic        m_valid, m_busy, m_done;
    logic [1:0]  m_sel;

    int total = 0;
    int bad = 0;
    logic [7:0] rx[$];

    always #5 clk = ~clk;

    function automatic logic [15:0] mux_model(input logic [1:0] s, input logic [3:0] r);
        case (s)
            2'b00:   return 16'h1000 | {12'h000, r};
            2'b01:   return 16'h2000 | {12'h000, r};
            2'b11:   return 16'h3000 | {12'h000, r};
            default: return 16'hDEAD;
        endcase
    endfunction

    assign reg_data  = override ? 16'hFFFF : mux_model(sel, reg_sel);
    assign reg_data0 = mux_model(sel0, reg_sel0);
    assign start     = go & ~use0;
    assign start0    = go & use0;
    assign m_data    = use0 ? tx_data0  : tx_data;
    assign m_valid   = use0 ? tx_valid0 : tx_valid;
    assign m_busy    = use0 ? busy0     : busy;
    assign m_done    = use0 ? done0     : done;
    assign m_sel     = use0 ? sel0      : sel;

    reg_dump_seq #(.SETTLE(1), .INCLUDE_INTERNAL(1'b1)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .sel(sel), .reg_sel(reg_sel), .reg_data(reg_data),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .busy(busy), .done(done)
    );

    reg_dump_seq #(.SETTLE(1), .INCLUDE_INTERNAL(1'b0)) dut0 (
        .clk(clk), .reset(reset), .start(start0), .abort(abort),
        .sel(sel0), .reg_sel(reg_sel0), .reg_data(reg_data0),
        .tx_data(tx_data0), .tx_valid(tx_valid0), .tx_ready(tx_ready),
        .busy(busy0), .done(done0)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_stream(input string tag, input bit incl);
        logic [7:0] e[$];
        int nerr;
        nerr = 0;
        for (int r = 0; r < 16; r++) begin
            e.push_back(8'(r)); e.push_back(8'h10); e.push_back(8'(r));
        end
        if (incl) begin
            for (int r = 0; r < 5; r++) begin
                e.push_back(8'h40 | 8'(r)); e.push_back(8'h20); e.push_back(8'(r));
            end
            e.push_back(8'hCE); e.push_back(8'h30); e.push_back(8'h0E);
            e.push_back(8'hCF); e.push_back(8'h30); e.push_back(8'h0F);
        end
        check({tag, "_len"}, 32'(rx.size()), 32'(e.size()));
        for (int i = 0; i < e.size() && i < rx.size(); i++) begin
            if (rx[i] !== e[i]) nerr++;
        end
        check({tag, "_bytes"}, 32'(nerr), 32'd0);
    endtask

    // One dump on the selected instance; mode bits: bp, iso, midstart.
    task automatic do_dump(input bit bp, input bit iso, input bit midstart,
                           output int done_at, output int busy_cycles,
                           output int nstall, output int hold_err, output int sel_off);
        int ncyc, iso_stall;
        logic prev_stall;
        logic [7:0] prev_data;
        rx.delete();
        done_at = 0; busy_cycles = 0; nstall = 0; hold_err = 0; sel_off = 0;
        iso_stall = 0; prev_stall = 1'b0; prev_data = 8'h00;
        go = 1'b1;
        tick();
        go = 1'b0;
        ncyc = 1;
        check("first_busy", {31'd0, m_busy}, 32'd1);
        while (done_at == 0 && ncyc < 400) begin
            tx_ready = bp ? ($urandom_range(0, 1) != 0) : 1'b1;
            if (iso) begin
                override = m_valid && rx.size() >= 9 && rx.size() <= 11;
                if (m_valid && rx.size() == 9 && iso_stall < 3) begin
                    tx_ready = 1'b0; iso_stall++;
                end
                if (m_valid && rx.size() == 10 && iso_stall < 5) begin
                    tx_ready = 1'b0; iso_stall++;
                end
            end
            go = midstart && (ncyc == 40);
            if (prev_stall && (!m_valid || m_data != prev_data)) hold_err++;
            if (m_busy) busy_cycles++;
            if (m_done) done_at = ncyc;
            if (m_sel != 2'b00) sel_off++;
            prev_stall = m_valid && !tx_ready;
            prev_data = m_data;
            if (prev_stall) nstall++;
            if (m_valid && tx_ready) rx.push_back(m_data);
            tick();
            ncyc++;
        end
        go = 1'b0;
        override = 1'b0;
        tx_ready = 1'b1;
    endtask

    initial begin
        int done_at, busy_cycles, nstall, hold_err, sel_off, found, done_seen;

        reset = 1'b1;
        tick(); tick();
        check("rst_main", {15'd0, sel, reg_sel, tx_data, tx_valid, busy, done}, 32'd0);
        check("rst_int0", {15'd0, sel0, reg_sel0, tx_data0, tx_valid0, busy0, done0}, 32'd0);
        reset = 1'b0;
        tick();

        // Full dump, ready high.
        use0 = 1'b0;
        do_dump(1'b0, 1'b0, 1'b0, done_at, busy_cycles, nstall, hold_err, sel_off);
        check_stream("full", 1'b1);
        check("full_b0", {24'd0, rx[0]}, 32'h00);
        check("full_b1", {24'd0, rx[1]}, 32'h10);
        check("full_b3", {24'd0, rx[3]}, 32'h01);
        check("full_pc_tag", {24'd0, rx[63]}, 32'hCE);
        check("full_ir_tag", {24'd0, rx[66]}, 32'hCF);
        check("full_ir_lo", {24'd0, rx[68]}, 32'h0F);
        check("full_done_at", 32'(done_at), 32'd116);
        check("full_busy", 32'(busy_cycles), 32'd115);
        tick();

        // Backpressure.
        do_dump(1'b1, 1'b0, 1'b0, done_at, busy_cycles, nstall, hold_err, sel_off);
        check_stream("bp", 1'b1);
        check("bp_hold", 32'(hold_err), 32'd0);
        check("bp_done_at", 32'(done_at), 32'(116 + nstall));
        check("bp_busy", 32'(busy_cycles), 32'(115 + nstall));
        tick();

        // Capture isolation on word 00/3.
        do_dump(1'b0, 1'b1, 1'b0, done_at, busy_cycles, nstall, hold_err, sel_off);
        check_stream("iso", 1'b1);
        check("iso_hi", {24'd0, rx[10]}, 32'h10);
        check("iso_lo", {24'd0, rx[11]}, 32'h03);
        check("iso_stalls", 32'(nstall), 32'd5);
        check("iso_done_at", 32'(done_at), 32'd121);
        tick();

        // Start pulse while busy is ignored.
        do_dump(1'b0, 1'b0, 1'b1, done_at, busy_cycles, nstall, hold_err, sel_off);
        check_stream("midstart", 1'b1);
        check("midstart_done_at", 32'(done_at), 32'd116);
        tick();

        // Group A only instance.
        use0 = 1'b1;
        do_dump(1'b0, 1'b0, 1'b0, done_at, busy_cycles, nstall, hold_err, sel_off);
        check_stream("a_only", 1'b0);
        check("a_only_last_tag", {24'd0, rx[45]}, 32'h0F);
        check("a_only_sel", 32'(sel_off), 32'd0);
        check("a_only_done_at", 32'(done_at), 32'd81);
        check("a_only_busy", 32'(busy_cycles), 32'd80);
        use0 = 1'b0;
        tick();

        // Abort during HI of word 01/2 (byte index 55).
        rx.delete();
        found = 0;
        go = 1'b1; tick(); go = 1'b0;
        for (int i = 0; i < 300; i++) begin
            tx_ready = 1'b1;
            if (tx_valid && rx.size() == 55) begin found = 1; break; end
            if (tx_valid) rx.push_back(tx_data);
            tick();
        end
        check("abort_reached", 32'(found), 32'd1);
        check("abort_hi_byte", {24'd0, tx_data}, 32'h20);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_valid_busy", {30'd0, tx_valid, busy}, 32'd0);
        check("abort_addr", {26'd0, sel, reg_sel}, 32'd0);
        done_seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (done || busy) done_seen++;
            tick();
        end
        check("abort_no_done", 32'(done_seen), 32'd0);
        go = 1'b1; tick(); go = 1'b0;
        check("restart_busy", {31'd0, busy}, 32'd1);
        found = 0;
        for (int i = 0; i < 20; i++) begin
            if (tx_valid) begin found = 1; break; end
            tick();
        end
        check("restart_valid", 32'(found), 32'd1);
        check("restart_tag", {24'd0, tx_data}, 32'h00);

        reset = 1'b1; tick(); tick(); reset = 1'b0; tick();

        // Asynchronous reset during LO of word 00/4 (byte index 14).
        rx.delete();
        found = 0;
        go = 1'b1; tick(); go = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tx_ready = 1'b1;
            if (tx_valid && rx.size() == 14) begin found = 1; break; end
            if (tx_valid) rx.push_back(tx_data);
            tick();
        end
        check("lo_reached", 32'(found), 32'd1);
        check("lo_byte", {24'd0, tx_data}, 32'h04);
        tx_ready = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("async_rst", {15'd0, sel, reg_sel, tx_data, tx_valid, busy, done}, 32'd0);
        tick();
        reset = 1'b0;
        tx_ready = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
